// File: rtl/assoc_cache_ctrl_if.sv
// CPU request/response and backing-RAM handshake bundle for assoc_cache_ctrl.
// slave = the cache itself, master = whoever drives the CPU side and answers the RAM side.
interface assoc_cache_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          enab;
   logic          rw;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          ready;
   logic          done;
   logic          hit;
   logic [DW-1:0] data_out;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport slave (
      input  enab, rw, addr, data, mem_rdata, mem_ack,
      output ready, done, hit, data_out, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output enab, rw, addr, data, mem_rdata, mem_ack,
      input  ready, done, hit, data_out, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// Fully-associative write-through/no-allocate cache with true-LRU in front of a req/ack RAM.
// Define CACHE_STATS_EN to add saturating hit/miss counters (o_hit_cnt, o_miss_cnt).
module assoc_cache_ctrl #(
   parameter int AW   = 8,
   parameter int DW   = 8,
   parameter int WAYS = 4
) (
   input  logic                 clk,
   input  logic                 clr,
   assoc_cache_ctrl_if.slave    bus
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]          o_hit_cnt,
   output logic [15:0]          o_miss_cnt
`endif
);
   localparam int LW = $clog2(WAYS);

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR, S_RESP} state_t;

   state_t          r_state, w_next;
   logic            r_rw;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_data;
   logic [WAYS-1:0] r_valid;
   logic [AW-1:0]   r_tag  [WAYS];
   logic [DW-1:0]   r_line [WAYS];
   logic [LW-1:0]   r_age  [WAYS];
   logic            r_hit;
   logic [DW-1:0]   r_data_out;

   logic            w_hit;
   logic [LW-1:0]   w_hit_idx;
   logic [LW-1:0]   w_victim;
   logic            w_touch;
   logic [LW-1:0]   w_touch_idx;

   // Lookup and victim choice; descending scans make the lowest index win.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      w_victim  = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (r_valid[i] && (r_tag[i] == r_addr)) begin
            w_hit     = 1'b1;
            w_hit_idx = LW'(i);
         end
         if (r_age[i] == LW'(WAYS - 1))
            w_victim = LW'(i);
      end
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!r_valid[i])
            w_victim = LW'(i);
      end
      w_touch     = ((r_state == S_LOOKUP) && w_hit) ||
                    ((r_state == S_MEM_RD) && bus.mem_ack);
      w_touch_idx = (r_state == S_LOOKUP) ? w_hit_idx : w_victim;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.enab) w_next = S_LOOKUP;
         S_LOOKUP: w_next = r_rw ? S_MEM_WR : (w_hit ? S_RESP : S_MEM_RD);
         S_MEM_RD: if (bus.mem_ack) w_next = S_RESP;
         S_MEM_WR: if (bus.mem_ack) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_rw       <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_valid    <= '0;
         r_hit      <= 1'b0;
         r_data_out <= '0;
         for (int i = 0; i < WAYS; i++) begin
            r_tag[i]  <= '0;
            r_line[i] <= '0;
            r_age[i]  <= LW'(i);
         end
      end else begin
         if ((r_state == S_IDLE) && bus.enab) begin
            r_rw   <= bus.rw;
            r_addr <= bus.addr;
            r_data <= bus.data;
         end
         if (r_state == S_LOOKUP) begin
            r_hit <= w_hit;
            if (w_hit && !r_rw) r_data_out        <= r_line[w_hit_idx];
            if (w_hit && r_rw)  r_line[w_hit_idx] <= r_data;
         end
         if ((r_state == S_MEM_RD) && bus.mem_ack) begin
            r_valid[w_victim] <= 1'b1;
            r_tag[w_victim]   <= r_addr;
            r_line[w_victim]  <= bus.mem_rdata;
            r_data_out        <= bus.mem_rdata;
         end
         // Ages stay a permutation: only younger ways age, the touched way becomes youngest.
         if (w_touch) begin
            for (int i = 0; i < WAYS; i++) begin
               if (LW'(i) == w_touch_idx)
                  r_age[i] <= '0;
               else if (r_age[i] < r_age[w_touch_idx])
                  r_age[i] <= r_age[i] + 1'b1;
            end
         end
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         o_hit_cnt  <= '0;
         o_miss_cnt <= '0;
      end else if (r_state == S_RESP) begin
         if (r_hit && (o_hit_cnt != 16'hFFFF))
            o_hit_cnt <= o_hit_cnt + 16'd1;
         else if (!r_hit && (o_miss_cnt != 16'hFFFF))
            o_miss_cnt <= o_miss_cnt + 16'd1;
      end
   end
`endif

   // Handshake outputs decode the state register so reset drops mem_req immediately.
   assign bus.ready     = (r_state == S_IDLE);
   assign bus.done      = (r_state == S_RESP);
   assign bus.hit       = r_hit;
   assign bus.data_out  = r_data_out;
   assign bus.mem_req   = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   assign bus.mem_we    = (r_state == S_MEM_WR);
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_data;
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: RAM model answers after a programmable number of request cycles.
module tb_assoc_cache_ctrl;
   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   assoc_cache_ctrl_if #(.AW(8), .DW(8)) bus();
`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt, miss_cnt;
`endif

   assoc_cache_ctrl #(.AW(8), .DW(8), .WAYS(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
`ifdef CACHE_STATS_EN
      ,
      .o_hit_cnt  (hit_cnt),
      .o_miss_cnt (miss_cnt)
`endif
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // RAM model: contents a ^ 0xA0, ack after lat request cycles.
   logic [7:0] mem [256];
   int         lat = 3;
   int         req_cyc = 0;
   int         acks = 0;
   int         unstable = 0;
   int         dones = 0;
   logic [7:0] last_addr = '0;
   logic [7:0] last_wdata = '0;
   logic       last_we = 1'b0;

   initial begin
      int cnt;
      cnt = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (bus.mem_req === 1'b1) begin
            cnt++;
            req_cyc++;
            if (cnt == 1) last_addr = bus.mem_addr;
            else if (bus.mem_addr !== last_addr) unstable++;
            if (cnt == lat) begin
               bus.mem_ack = 1'b1;
               acks++;
               last_we    = bus.mem_we;
               last_wdata = bus.mem_wdata;
               if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
               else            bus.mem_rdata = mem[bus.mem_addr];
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic req(input logic rw, input logic [7:0] a, input logic [7:0] d,
                      output logic h, output logic [7:0] q, output int cyc);
      int w;
      w = 0;
      @(negedge clk);
      while (bus.ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (bus.ready !== 1'b1) chk("ready_timeout", 0, 1);
      bus.enab = 1'b1;
      bus.rw   = rw;
      bus.addr = a;
      bus.data = d;
      @(negedge clk);
      bus.enab = 1'b0;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (bus.done !== 1'b1) chk("done_timeout", 0, 1);
      h = bus.hit;
      q = bus.data_out;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr      = 1'b0;
      bus.enab = 1'b0;
      repeat (2) @(negedge clk);
      clr = 1'b1;
   endtask

   logic       h;
   logic [7:0] q;
   int         c;

   initial begin
      int base;
      int w;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA0;
      bus.enab = 1'b0;
      bus.rw   = 1'b0;
      bus.addr = '0;
      bus.data = '0;

      // Reset state
      #2 clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.ready, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_hit", bus.hit, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      @(negedge clk);
      clr = 1'b1;

      // Read miss then read hit
      req_cyc = 0;
      req(1'b0, 8'h0F, 8'h00, h, q, c);
      chk("t1_miss_hit", h, 0);
      chk("t1_miss_data", q, 8'hAF);
      chk("t1_req_cycles", req_cyc, 3);
      chk("t1_miss_latency", c, 5);
      req(1'b0, 8'h0F, 8'h00, h, q, c);
      chk("t1_hit_hit", h, 1);
      chk("t1_hit_data", q, 8'hAF);
      chk("t1_hit_latency", c, 2);
      chk("t1_hit_no_mem", req_cyc, 3);

      // Write-through, no-allocate
      req(1'b1, 8'h01, 8'hE0, h, q, c);
      chk("t2_wmiss_hit", h, 0);
      chk("t2_wmiss_we", last_we, 1);
      chk("t2_wmiss_wdata", last_wdata, 8'hE0);
      chk("t2_wmiss_addr", last_addr, 8'h01);
      chk("t2_wmiss_latency", c, 5);
      req(1'b0, 8'h01, 8'h00, h, q, c);
      chk("t2_rd_after_wmiss_hit", h, 0);
      chk("t2_rd_after_wmiss_data", q, 8'hE0);
      req(1'b1, 8'h01, 8'h11, h, q, c);
      chk("t2_whit_hit", h, 1);
      chk("t2_whit_we", last_we, 1);
      chk("t2_whit_wdata", last_wdata, 8'h11);
      req(1'b0, 8'h01, 8'h00, h, q, c);
      chk("t2_rd_after_whit_hit", h, 1);
      chk("t2_rd_after_whit_data", q, 8'h11);

      // LRU eviction
      do_reset();
      for (int a = 8'h10; a <= 8'h13; a++) begin
         req(1'b0, 8'(a), 8'h00, h, q, c);
         chk("t3_fill_hit", h, 0);
      end
      req(1'b0, 8'h10, 8'h00, h, q, c);
      chk("t3_rd10_hit", h, 1);
      req(1'b0, 8'h14, 8'h00, h, q, c);
      chk("t3_rd14_hit", h, 0);
      chk("t3_rd14_data", q, 8'hB4);
      req(1'b0, 8'h11, 8'h00, h, q, c);
      chk("t3_rd11_evicted", h, 0);
      chk("t3_rd11_data", q, 8'hB1);
      req(1'b0, 8'h10, 8'h00, h, q, c);
      chk("t3_rd10_kept", h, 1);
      chk("t3_rd10_data", q, 8'hB0);
      req(1'b0, 8'h13, 8'h00, h, q, c);
      chk("t3_rd13_kept", h, 1);
      req(1'b0, 8'h12, 8'h00, h, q, c);
      chk("t3_rd12_evicted", h, 0);

      // enab held high with a changing address across a miss
      base = acks;
      unstable = 0;
      @(negedge clk);
      bus.enab = 1'b1;
      bus.rw   = 1'b0;
      bus.addr = 8'h20;
      w = 0;
      while (bus.done !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
         if (bus.done !== 1'b1) bus.addr = bus.addr + 8'd1;
      end
      bus.enab = 1'b0;
      chk("t4_done_seen", bus.done, 1);
      chk("t4_served_addr", last_addr, 8'h20);
      chk("t4_data", bus.data_out, 8'h80);
      chk("t4_addr_stable", unstable, 0);
      chk("t4_one_request", acks - base, 1);
      repeat (3) @(negedge clk);
      chk("t4_no_extra_req", acks - base, 1);
      chk("t4_ready_after", bus.ready, 1);

      // Reset in the middle of a RAM read
      lat = 10;
      base = dones;
      @(negedge clk);
      bus.enab = 1'b1;
      bus.rw   = 1'b0;
      bus.addr = 8'h30;
      @(negedge clk);
      bus.enab = 1'b0;
      w = 0;
      while (bus.mem_req !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("t5_mem_req_up", bus.mem_req, 1);
      repeat (2) @(negedge clk);
      clr = 1'b0;
      #1;
      chk("t5_mem_req_drop", bus.mem_req, 0);
      chk("t5_ready", bus.ready, 1);
      chk("t5_no_done", bus.done, 0);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_done_count", dones - base, 0);
      lat = 3;
      req(1'b0, 8'h13, 8'h00, h, q, c);
      chk("t5_rd13_miss", h, 0);
      req(1'b0, 8'h20, 8'h00, h, q, c);
      chk("t5_rd20_miss", h, 0);

`ifdef CACHE_STATS_EN
      do_reset();
      chk("t6_rst_hit_cnt", hit_cnt, 0);
      chk("t6_rst_miss_cnt", miss_cnt, 0);
      req(1'b0, 8'h40, 8'h00, h, q, c);
      for (int k = 0; k < 3; k++) req(1'b0, 8'h40, 8'h00, h, q, c);
      req(1'b0, 8'h41, 8'h00, h, q, c);
      @(negedge clk);
      chk("t6_hit_cnt", hit_cnt, 3);
      chk("t6_miss_cnt", miss_cnt, 2);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
